// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the IF/ID/EX core: load-use scoreboard,
// jump/decode-error flush sequencing, PC redirect and stall-cycle counting.
module pipe_ctrl #(
    parameter int          SB_DEPTH  = 4,
    parameter int          LOAD_LAT  = 2,
    parameter int          FLUSH_CYC = 2,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic        id_rs1_used_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_is_load_i,
    input  logic        id_err_i,
    input  logic        ex_busy_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    output logic        hold_o,
    output logic        bubble_o,
    output logic        flush_o,
    output logic        pc_set_o,
    output logic [31:0] pc_set_addr_o,
    output logic        trap_o,
    output logic [31:0] trap_pc_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

    localparam logic [2:0] LAT_INIT  = 3'(LOAD_LAT);
    localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYC - 1);

    state_t              state;
    logic [1:0]          fcnt;
    logic [SB_DEPTH-1:0] sb_vld;
    logic [4:0]          sb_rd  [SB_DEPTH];
    logic [2:0]          sb_cnt [SB_DEPTH];

    logic                in_run;
    logic                raw_hit;
    logic                sb_full;
    logic                taken;
    logic [SB_DEPTH-1:0] sb_free;
    logic [SB_DEPTH-1:0] alloc_oh;
    logic                do_jump;
    logic                do_trap;
    logic                do_busy;
    logic                do_stall;
    logic                run_ok;
    logic                do_issue;
    logic                do_alloc;

    // Hazard lookup; an entry on its last count still blocks readers but is free for allocation
    always_comb begin
        raw_hit = 1'b0;
        sb_free = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld[i] && id_rs1_used_i && (id_rs1_addr_i != 5'd0) && (sb_rd[i] == id_rs1_addr_i))
                raw_hit = 1'b1;
            if (sb_vld[i] && id_rs2_used_i && (id_rs2_addr_i != 5'd0) && (sb_rd[i] == id_rs2_addr_i))
                raw_hit = 1'b1;
            sb_free[i] = !sb_vld[i] || (sb_cnt[i] == 3'd1);
        end
    end

    always_comb begin
        taken    = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (!taken && sb_free[i]) begin
                alloc_oh[i] = 1'b1;
                taken       = 1'b1;
            end
        end
    end

    assign sb_full  = ~|sb_free;
    assign in_run   = (state == RUN);

    // Priority chain: jump > trap > busy > scoreboard stall > issue
    assign do_jump  = !rst && ex_jump_i;
    assign do_trap  = !rst && !ex_jump_i && in_run && id_valid_i && id_err_i;
    assign do_busy  = !rst && !ex_jump_i && !do_trap && in_run && ex_busy_i;
    assign run_ok   = !rst && !ex_jump_i && in_run && !ex_busy_i && id_valid_i && !id_err_i;
    assign do_stall = run_ok && (raw_hit || (id_is_load_i && sb_full));
    assign do_issue = run_ok && !do_stall;
    assign do_alloc = do_issue && id_is_load_i && (id_rd_addr_i != 5'd0);

    assign hold_o        = do_busy || do_stall;
    assign bubble_o      = do_stall;
    assign flush_o       = !rst && (ex_jump_i || do_trap || !in_run);
    assign pc_set_o      = do_jump || do_trap;
    assign pc_set_addr_o = do_jump ? ex_jump_addr_i : (do_trap ? TRAP_VEC : 32'd0);
    assign trap_o        = do_trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fcnt        <= 2'd0;
            sb_vld      <= '0;
            trap_pc_o   <= 32'd0;
            stall_cnt_o <= 32'd0;
        end else begin
            if (hold_o)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (do_trap)
                trap_pc_o <= id_pc_i;

            if (ex_jump_i) begin
                state <= FLUSH;
                fcnt  <= FCNT_INIT;
            end else if (do_trap) begin
                state <= TRAP;
                fcnt  <= FCNT_INIT;
            end else if (!in_run) begin
                if (fcnt == 2'd0)
                    state <= RUN;
                else
                    fcnt <= fcnt - 2'd1;
            end

            // Loads keep counting through busy and flush; a retiring slot may be refilled on the same edge
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (do_alloc && alloc_oh[i]) begin
                    sb_vld[i] <= 1'b1;
                    sb_rd[i]  <= id_rd_addr_i;
                    sb_cnt[i] <= LAT_INIT;
                end else if (sb_vld[i]) begin
                    sb_cnt[i] <= sb_cnt[i] - 3'd1;
                    if (sb_cnt[i] == 3'd1)
                        sb_vld[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table on the default
// instance, plus hand sequences on a long-latency instance for full-scoreboard and reset cases.
module tb_pipe_ctrl;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic [4:0]  rd;
        logic        ld;
        logic        err;
        logic        busy;
        logic        jmp;
        logic [31:0] jaddr;
        logic [100:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    // Instance A: default parameters
    logic        a_rst, a_valid, a_rs1u, a_rs2u, a_ld, a_err, a_busy, a_jmp;
    logic [31:0] a_pc, a_jaddr;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic        a_hold, a_bubble, a_flush, a_pcset, a_trap;
    logic [31:0] a_paddr, a_tpc, a_scnt;

    // Instance B: LOAD_LAT=5 so four loads can be outstanding at once
    logic        b_rst, b_valid, b_rs1u, b_rs2u, b_ld, b_err;
    logic [31:0] b_pc;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic        b_hold, b_bubble, b_flush, b_pcset, b_trap;
    logic [31:0] b_paddr, b_tpc, b_scnt;

    pipe_ctrl u_a (
        .clk(clk), .rst(a_rst), .id_valid_i(a_valid), .id_pc_i(a_pc),
        .id_rs1_addr_i(a_rs1), .id_rs1_used_i(a_rs1u), .id_rs2_addr_i(a_rs2), .id_rs2_used_i(a_rs2u),
        .id_rd_addr_i(a_rd), .id_is_load_i(a_ld), .id_err_i(a_err), .ex_busy_i(a_busy),
        .ex_jump_i(a_jmp), .ex_jump_addr_i(a_jaddr), .hold_o(a_hold), .bubble_o(a_bubble),
        .flush_o(a_flush), .pc_set_o(a_pcset), .pc_set_addr_o(a_paddr), .trap_o(a_trap),
        .trap_pc_o(a_tpc), .stall_cnt_o(a_scnt)
    );

    pipe_ctrl #(.LOAD_LAT(5)) u_b (
        .clk(clk), .rst(b_rst), .id_valid_i(b_valid), .id_pc_i(b_pc),
        .id_rs1_addr_i(b_rs1), .id_rs1_used_i(b_rs1u), .id_rs2_addr_i(b_rs2), .id_rs2_used_i(b_rs2u),
        .id_rd_addr_i(b_rd), .id_is_load_i(b_ld), .id_err_i(b_err), .ex_busy_i(1'b0),
        .ex_jump_i(1'b0), .ex_jump_addr_i(32'd0), .hold_o(b_hold), .bubble_o(b_bubble),
        .flush_o(b_flush), .pc_set_o(b_pcset), .pc_set_addr_o(b_paddr), .trap_o(b_trap),
        .trap_pc_o(b_tpc), .stall_cnt_o(b_scnt)
    );

    wire [100:0] out_a = {a_hold, a_bubble, a_flush, a_pcset, a_paddr, a_trap, a_tpc, a_scnt};
    wire [100:0] out_b = {b_hold, b_bubble, b_flush, b_pcset, b_paddr, b_trap, b_tpc, b_scnt};

    function automatic logic [100:0] ex(input logic h, b, f, ps, input logic [31:0] pa,
                                        input logic t, input logic [31:0] tpc, sc);
        return {h, b, f, ps, pa, t, tpc, sc};
    endfunction

    task automatic row(input logic r, v, input logic [31:0] pc, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic [4:0] rd,
                       input logic ld, er, bz, jp, input logic [31:0] ja, input logic [100:0] e);
        vec_t x;
        x.rst = r; x.valid = v; x.pc = pc; x.rs1 = s1; x.rs1u = u1; x.rs2 = s2; x.rs2u = u2;
        x.rd = rd; x.ld = ld; x.err = er; x.busy = bz; x.jmp = jp; x.jaddr = ja; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [100:0] act, input logic [100:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {h,b,f,ps,pa,t,tpc,sc}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_b(input logic r, v, input logic [31:0] pc, input logic [4:0] s1, input logic u1,
                           input logic [4:0] s2, input logic u2, input logic [4:0] rd, input logic ld, er);
        b_rst = r; b_valid = v; b_pc = pc; b_rs1 = s1; b_rs1u = u1; b_rs2 = s2; b_rs2u = u2;
        b_rd = rd; b_ld = ld; b_err = er;
    endtask

    task automatic step_b(input string name, input logic r, v, input logic [31:0] pc,
                          input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2,
                          input logic [4:0] rd, input logic ld, er, input logic [100:0] e);
        @(posedge clk); #1;
        drive_b(r, v, pc, s1, u1, s2, u2, rd, ld, er);
        @(negedge clk);
        chk(name, out_b, e);
    endtask

    initial begin
        // rst valid pc     rs1 u rs2 u rd ld er bz jp jaddr     expected {h,b,f,ps,pa,t,tpc,sc}
        row(1, 1, 32'h0,  5, 1, 0, 0, 0, 0, 1, 1, 1, 32'h80,  ex(0,0,0,0,32'h0,  0,32'h0, 0));
        // load x5 then dependent add: two stall cycles
        row(0, 1, 32'h10, 0, 0, 0, 0, 5, 1, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h0, 0));
        row(0, 1, 32'h14, 5, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,   ex(1,1,0,0,32'h0,  0,32'h0, 0));
        row(0, 1, 32'h14, 5, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,   ex(1,1,0,0,32'h0,  0,32'h0, 1));
        row(0, 1, 32'h14, 5, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h0, 2));
        // busy masks the hazard while the load retires underneath
        row(0, 1, 32'h18, 0, 0, 0, 0, 5, 1, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h0, 2));
        row(0, 1, 32'h1c, 5, 1, 1, 1, 6, 0, 0, 1, 0, 32'h0,   ex(1,0,0,0,32'h0,  0,32'h0, 2));
        row(0, 1, 32'h1c, 5, 1, 1, 1, 6, 0, 0, 1, 0, 32'h0,   ex(1,0,0,0,32'h0,  0,32'h0, 3));
        row(0, 1, 32'h1c, 5, 1, 1, 1, 6, 0, 0, 1, 0, 32'h0,   ex(1,0,0,0,32'h0,  0,32'h0, 4));
        row(0, 1, 32'h1c, 5, 1, 1, 1, 6, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h0, 5));
        // decode error trap, err held high during TRAP
        row(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,   ex(0,0,1,1,32'h100,1,32'h0, 5));
        row(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h44,5));
        row(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h44,5));
        row(0, 1, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h44,5));
        // jump beats a simultaneous decode error
        row(0, 1, 32'h50, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h80,  ex(0,0,1,1,32'h80, 0,32'h44,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h44,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h44,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h44,5));
        // trap beats busy, then a jump during TRAP restarts as FLUSH
        row(0, 1, 32'h60, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0,   ex(0,0,1,1,32'h100,1,32'h44,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, ex(0,0,1,1,32'h200,0,32'h60,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h60,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,1,0,32'h0,  0,32'h60,5));
        row(0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h60,5));
        // hazard through rs2, then unused sources never stall
        row(0, 1, 32'h64, 0, 0, 0, 0, 7, 1, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h60,5));
        row(0, 1, 32'h68, 3, 1, 7, 1, 8, 0, 0, 0, 0, 32'h0,   ex(1,1,0,0,32'h0,  0,32'h60,5));
        row(0, 1, 32'h68, 3, 1, 7, 1, 8, 0, 0, 0, 0, 32'h0,   ex(1,1,0,0,32'h0,  0,32'h60,6));
        row(0, 1, 32'h68, 3, 1, 7, 1, 8, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h60,7));
        row(0, 1, 32'h6c, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h60,7));
        row(0, 1, 32'h70, 9, 0, 9, 0,10, 0, 0, 0, 0, 32'h0,   ex(0,0,0,0,32'h0,  0,32'h60,7));

        a_rst = 1'b1; a_valid = 1'b0; a_pc = '0; a_rs1 = '0; a_rs1u = 1'b0; a_rs2 = '0; a_rs2u = 1'b0;
        a_rd = '0; a_ld = 1'b0; a_err = 1'b0; a_busy = 1'b0; a_jmp = 1'b0; a_jaddr = '0;
        drive_b(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive_b(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            a_rst = vecs[i].rst; a_valid = vecs[i].valid; a_pc = vecs[i].pc;
            a_rs1 = vecs[i].rs1; a_rs1u = vecs[i].rs1u; a_rs2 = vecs[i].rs2; a_rs2u = vecs[i].rs2u;
            a_rd = vecs[i].rd; a_ld = vecs[i].ld; a_err = vecs[i].err; a_busy = vecs[i].busy;
            a_jmp = vecs[i].jmp; a_jaddr = vecs[i].jaddr;
            @(negedge clk);
            chk($sformatf("row%0d", i), out_a, vecs[i].exp);
        end

        // Reset during TRAP with two loads outstanding abandons everything
        step_b("rst_ld5",  0, 1, 32'h0,  0, 0, 0, 0, 5, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("rst_ld6",  0, 1, 32'h4,  0, 0, 0, 0, 6, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("rst_trap", 0, 1, 32'h70, 0, 0, 0, 0, 0, 0, 1, ex(0,0,1,1,32'h100,1,32'h0, 0));
        step_b("rst_hi",   1, 1, 32'h70, 0, 0, 0, 0, 0, 0, 1, ex(0,0,0,0,32'h0,  0,32'h70,0));
        step_b("rst_dep",  0, 1, 32'h74, 5, 1, 6, 1, 7, 0, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        // Four loads fill the scoreboard; the fifth issues when the oldest retires
        step_b("full_ld1", 0, 1, 32'h80, 0, 0, 0, 0, 1, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("full_ld2", 0, 1, 32'h84, 0, 0, 0, 0, 2, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("full_ld3", 0, 1, 32'h88, 0, 0, 0, 0, 3, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("full_ld4", 0, 1, 32'h8c, 0, 0, 0, 0, 4, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 0));
        step_b("full_stl", 0, 1, 32'h90, 0, 0, 0, 0, 8, 1, 0, ex(1,1,0,0,32'h0,  0,32'h0, 0));
        step_b("full_iss", 0, 1, 32'h90, 0, 0, 0, 0, 8, 1, 0, ex(0,0,0,0,32'h0,  0,32'h0, 1));
        step_b("full_dep", 0, 1, 32'h94, 8, 1, 0, 0, 9, 0, 0, ex(1,1,0,0,32'h0,  0,32'h0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
